// File: rtl/sprite_draw_if.sv
// sprite_draw_if: command strobe, sprite ROM port and VGA adapter signals of the sprite draw engine
interface sprite_draw_if #(
  parameter int ID_W = 5,
  parameter int COLOUR_W = 3,
  parameter int ADDR_W = 13
);
  logic start;
  logic [1:0] cmd;
  logic [ID_W-1:0] spriteId;
  logic [7:0] xIn;
  logic [6:0] yIn;
  logic [COLOUR_W-1:0] fillColour;
  logic [ADDR_W-1:0] romAddr;
  logic [COLOUR_W-1:0] romData;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [COLOUR_W-1:0] vgaColour;
  logic vgaPlot;
  logic busy;
  logic done;
  modport master(
    output start, cmd, spriteId, xIn, yIn, fillColour, romData,
    input romAddr, vgaX, vgaY, vgaColour, vgaPlot, busy, done
  );
  modport slave(
    input start, cmd, spriteId, xIn, yIn, fillColour, romData,
    output romAddr, vgaX, vgaY, vgaColour, vgaPlot, busy, done
  );
endinterface

// File: rtl/sprite_draw_engine.sv
// sprite_draw_engine: walks sprite, erase-rectangle or full-screen pixels and plots them to the VGA adapter
module sprite_draw_engine #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int COLOUR_W = 3,
  parameter int ID_W = 5,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = 3'b101
) (
  input logic clk,
  input logic resetn,
  sprite_draw_if.slave bus
);
  localparam int ADDR_W = ID_W + $clog2(SPRITE_W * SPRITE_H);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, nextState;
  logic [1:0] cmdL;
  logic [ID_W-1:0] idL;
  logic [7:0] xL;
  logic [6:0] yL;
  logic [COLOUR_W-1:0] fillL;
  logic [7:0] col, colMax;
  logic [6:0] row, rowMax;
  logic isClr, isSprite, lastCol, lastRow, accept;
  logic [8:0] pixX, s1X;
  logic [7:0] pixY, s1Y;
  logic s1Valid, plotNow;
  logic [COLOUR_W-1:0] colourNow;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [COLOUR_W-1:0] vgaColour;
  logic vgaPlot, busyR, doneR;
  always_comb begin
    isClr = cmdL == 2'b10;
    isSprite = cmdL == 2'b00;
    colMax = isClr ? 8'(X_SCREEN_PIXELS - 1) : 8'(SPRITE_W - 1);
    rowMax = isClr ? 7'(Y_SCREEN_PIXELS - 1) : 7'(SPRITE_H - 1);
    lastCol = col == colMax;
    lastRow = row == rowMax;
    // the done-pulse cycle is still treated as busy for a new strobe
    accept = state == IDLE && bus.start && !doneR;
    nextState = state == IDLE ? (accept ? (bus.cmd == 2'b11 ? DONE : RUN) : IDLE)
              : state == RUN ? ((lastCol && lastRow) ? DRAIN : RUN)
              : state == DRAIN ? DONE : IDLE;
    pixX = {1'b0, xL} + {1'b0, col};
    pixY = {1'b0, yL} + {1'b0, row};
    plotNow = s1Valid && s1X < 9'(X_SCREEN_PIXELS) && s1Y < 8'(Y_SCREEN_PIXELS)
              && !(isSprite && bus.romData == TRANSPARENT);
    colourNow = isSprite ? bus.romData : fillL;
  end
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else state <= nextState;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmdL <= '0;
      idL <= '0;
      xL <= '0;
      yL <= '0;
      fillL <= '0;
      col <= '0;
      row <= '0;
      s1Valid <= 1'b0;
      s1X <= '0;
      s1Y <= '0;
      vgaX <= '0;
      vgaY <= '0;
      vgaColour <= '0;
      vgaPlot <= 1'b0;
      busyR <= 1'b0;
      doneR <= 1'b0;
    end else begin
      busyR <= nextState != IDLE;
      doneR <= state == DONE;
      s1Valid <= state == RUN;
      s1X <= pixX;
      s1Y <= pixY;
      vgaPlot <= plotNow;
      if (plotNow) begin
        vgaX <= s1X[7:0];
        vgaY <= s1Y[6:0];
        vgaColour <= colourNow;
      end
      if (accept) begin
        cmdL <= bus.cmd;
        idL <= bus.spriteId;
        xL <= bus.cmd == 2'b10 ? 8'd0 : bus.xIn;
        yL <= bus.cmd == 2'b10 ? 7'd0 : bus.yIn;
        fillL <= bus.fillColour;
        col <= '0;
        row <= '0;
      end else if (state == RUN) begin
        col <= lastCol ? 8'd0 : col + 8'd1;
        if (lastCol) row <= lastRow ? 7'd0 : row + 7'd1;
      end
    end
  end
  assign bus.romAddr = ADDR_W'(idL) * ADDR_W'(SPRITE_W * SPRITE_H)
                     + ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
  assign bus.vgaX = vgaX;
  assign bus.vgaY = vgaY;
  assign bus.vgaColour = vgaColour;
  assign bus.vgaPlot = vgaPlot;
  assign bus.busy = busyR;
  assign bus.done = doneR;
endmodule

// File: tb/tb_sprite_draw_engine.sv
// tb_sprite_draw_engine: directed commands with a plot/done scoreboard checked by an independent monitor
module tb_sprite_draw_engine;
  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int cyc;
  } pix_t;
  logic clk = 1'b0;
  logic resetn;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int e0 = 0;
  int romMode = 0;
  pix_t expQ[$];
  int doneQ[$];
  pix_t e;
  int d;
  sprite_draw_if #(.ID_W(5), .COLOUR_W(3), .ADDR_W(13)) bus();
  sprite_draw_engine dut(.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [2:0] romFn(input logic [12:0] a, input int mode);
    if (mode == 0) return 3'd3;
    return a[3:0] == 4'd0 ? 3'b101 : (a[4] ? a[10:8] : {1'b0, a[1:0]});
  endfunction
  always @(posedge clk) bus.romData <= romFn(bus.romAddr, romMode);
  always @(negedge clk) begin
    if (bus.vgaPlot) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL plot: unexpected plot (%0d,%0d) c%0d at cycle %0d, required none", bus.vgaX, bus.vgaY, bus.vgaColour, cyc);
      end else begin
        e = expQ.pop_front();
        if (bus.vgaX !== e.x || bus.vgaY !== e.y || bus.vgaColour !== e.c || cyc != e.cyc) begin
          errors++;
          $display("FAIL plot: got (%0d,%0d) c%0d at cycle %0d, required (%0d,%0d) c%0d at cycle %0d",
                   bus.vgaX, bus.vgaY, bus.vgaColour, cyc, e.x, e.y, e.c, e.cyc);
        end
      end
    end
    if (bus.done) begin
      checks++;
      if (doneQ.size() == 0) begin
        errors++;
        $display("FAIL done: unexpected done at cycle %0d, required none", cyc);
      end else begin
        d = doneQ.pop_front();
        if (cyc != d || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL done: got done at cycle %0d busy=%0b, required cycle %0d busy=0", cyc, bus.busy, d);
        end
      end
    end
  end
  task automatic issue(input logic [1:0] c, input logic [4:0] id, input logic [7:0] x, input logic [6:0] y, input logic [2:0] f);
    @(negedge clk);
    bus.cmd = c;
    bus.spriteId = id;
    bus.xIn = x;
    bus.yIn = y;
    bus.fillColour = f;
    bus.start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic pushPix(input int x, input int y, input int c, input int k);
    expQ.push_back('{x: 8'(x), y: 7'(y), c: 3'(c), cyc: e0 + 2 + k});
  endtask
  task automatic waitDrain(input int bound);
    int n = 0;
    while ((expQ.size() != 0 || doneQ.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expQ.size() != 0 || doneQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d plots and %0d done pulses outstanding, required 0", expQ.size(), doneQ.size());
      expQ.delete();
      doneQ.delete();
    end
    repeat (3) @(negedge clk);
  endtask
  initial begin
    resetn = 1'b0;
    bus.start = 1'b0;
    bus.cmd = 2'b00;
    bus.spriteId = '0;
    bus.xIn = '0;
    bus.yIn = '0;
    bus.fillColour = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.vgaPlot !== 1'b0) begin
        errors++;
        $display("FAIL idle: busy=%0b done=%0b plot=%0b, required 0 0 0", bus.busy, bus.done, bus.vgaPlot);
      end
    end
    // solid sprite: every pixel plotted row-major
    romMode = 0;
    issue(2'b00, 5'd2, 8'd40, 7'd30, 3'd0);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) pushPix(40 + c, 30 + r, 3, r * 16 + c);
    doneQ.push_back(e0 + 258);
    waitDrain(400);
    // transparent column 0, colours depend on sprite id and row/col
    romMode = 1;
    issue(2'b00, 5'd6, 8'd20, 7'd50, 3'd0);
    for (int r = 0; r < 16; r++)
      for (int c = 1; c < 16; c++) pushPix(20 + c, 50 + r, (r % 2 == 1) ? 6 : c % 4, r * 16 + c);
    doneQ.push_back(e0 + 258);
    waitDrain(400);
    // erase rectangle clipped at the bottom-right corner
    issue(2'b01, 5'd9, 8'd150, 7'd112, 3'd0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++) pushPix(150 + c, 112 + r, 0, r * 16 + c);
    doneQ.push_back(e0 + 258);
    waitDrain(400);
    // clear screen ignores x/y inputs; a mid-command start must be ignored
    issue(2'b10, 5'd0, 8'd33, 7'd44, 3'd7);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) pushPix(x, y, 7, y * 160 + x);
    doneQ.push_back(e0 + 19202);
    repeat (500) @(negedge clk);
    bus.cmd = 2'b01;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDrain(20000);
    // reset twenty edges into a sprite draw
    romMode = 0;
    issue(2'b00, 5'd2, 8'd40, 7'd30, 3'd0);
    for (int k = 0; k < 18; k++) pushPix(40 + k % 16, 30 + k / 16, 3, k);
    while (cyc < e0 + 19) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.vgaPlot !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midreset: plot=%0b busy=%0b done=%0b, required 0 0 0", bus.vgaPlot, bus.busy, bus.done);
    end
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    waitDrain(10);
    // reserved command completes at once with no plots
    issue(2'b11, 5'd0, 8'd0, 7'd0, 3'd0);
    doneQ.push_back(e0 + 1);
    waitDrain(20);
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
